// File: rtl/servo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Servo_PKG : servo position type and park position                    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package Servo_PKG;

   typedef logic [7:0] servo_pos_t;

   localparam servo_pos_t SERVO_POS_UP = 8'h00;

endpackage
`default_nettype wire

// File: rtl/stepper_motion_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | MotorsCtrl_PKG : motion FSM states and default stepper timing        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package MotorsCtrl_PKG;

   localparam int STEPPER_PULSE_NUM_X_BITS = 16;
   localparam int STEPPER_PULSE_NUM_Y_BITS = 16;

   localparam int DEF_STEP_PERIOD_CYCLES  = 50;
   localparam int DEF_STEP_HIGH_CYCLES    = 10;
   localparam int DEF_SERVO_SETTLE_CYCLES = 1000;

   typedef enum logic [1:0] {
      SM_IDLE       = 2'd0,
      SM_SERVO_WAIT = 2'd1,
      SM_STEPPING   = 2'd2,
      SM_DONE       = 2'd3
   } stepper_motion_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/stepper_motion_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stepper_motion_ctrl_if : motors-control command handshake            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface stepper_motion_ctrl_if
   import MotorsCtrl_PKG::*;
   import Servo_PKG::*;
#(
   parameter int PULSE_NUM_X_BITS = STEPPER_PULSE_NUM_X_BITS,
   parameter int PULSE_NUM_Y_BITS = STEPPER_PULSE_NUM_Y_BITS
) ();

   logic [PULSE_NUM_X_BITS-1:0] pulse_num_x;
   logic [PULSE_NUM_Y_BITS-1:0] pulse_num_y;
   servo_pos_t                  servo_pos;
   logic                        trigger;
   logic                        rdy;
   logic                        done;

   modport master (
      output pulse_num_x, pulse_num_y, servo_pos, trigger,
      input  rdy, done
   );

   modport slave (
      input  pulse_num_x, pulse_num_y, servo_pos, trigger,
      output rdy, done
   );

endinterface
`default_nettype wire

// File: rtl/stepper_motion_ctrl_step_pulse_shaper.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | step_pulse_shaper : stretches a one-cycle request to HIGH_CYCLES     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module step_pulse_shaper
   import MotorsCtrl_PKG::*;
#(
   parameter int HIGH_CYCLES = DEF_STEP_HIGH_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic step_req_i,
   output logic step_o
);

   localparam int               CNT_W    = $clog2(HIGH_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(HIGH_CYCLES - 1);

   logic             step_q, step_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      step_d = step_q;
      cnt_d  = cnt_q;
      if (step_req_i) begin
         step_d = 1'b1;
         cnt_d  = CNT_INIT;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end else begin
         step_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         step_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         step_q <= step_d;
         cnt_q  <= cnt_d;
      end
   end

   assign step_o = step_q;

endmodule
`default_nettype wire

// File: rtl/stepper_motion_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stepper_motion_ctrl : servo-then-stepper move sequencer              |
// | Option: STEPPER_MOTION_CTRL_INTERP_EN selects linear interpolation   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module stepper_motion_ctrl
   import MotorsCtrl_PKG::*;
   import Servo_PKG::*;
#(
   parameter int PULSE_NUM_X_BITS    = STEPPER_PULSE_NUM_X_BITS,
   parameter int PULSE_NUM_Y_BITS    = STEPPER_PULSE_NUM_Y_BITS,
   parameter int STEP_PERIOD_CYCLES  = DEF_STEP_PERIOD_CYCLES,
   parameter int STEP_HIGH_CYCLES    = DEF_STEP_HIGH_CYCLES,
   parameter int SERVO_SETTLE_CYCLES = DEF_SERVO_SETTLE_CYCLES
) (
   input  logic                 clk,
   input  logic                 reset,
   stepper_motion_ctrl_if.slave cmd,
   output logic                 step_x,
   output logic                 step_y,
   output logic                 dir_x,
   output logic                 dir_y,
   output servo_pos_t           servo_pos_out
);

   localparam int MAG_W = max_int(PULSE_NUM_X_BITS, PULSE_NUM_Y_BITS);
   localparam int TMR_W = $clog2(STEP_PERIOD_CYCLES);
   localparam int SET_W = $clog2(SERVO_SETTLE_CYCLES + 1);

   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(STEP_PERIOD_CYCLES - 1);
   localparam logic [SET_W-1:0] SET_INIT = SET_W'(SERVO_SETTLE_CYCLES - 1);

   localparam logic [1:0] ST_IDLE       = 2'(SM_IDLE);
   localparam logic [1:0] ST_SERVO_WAIT = 2'(SM_SERVO_WAIT);
   localparam logic [1:0] ST_STEPPING   = 2'(SM_STEPPING);
   localparam logic [1:0] ST_DONE       = 2'(SM_DONE);

   logic [1:0]       state_q, state_d;
   logic             rdy_q, rdy_d;
   logic             done_q, done_d;
   logic             dir_x_q, dir_x_d;
   logic             dir_y_q, dir_y_d;
   servo_pos_t       servo_q, servo_d;
   logic [MAG_W-1:0] mag_x_q, mag_x_d;
   logic [MAG_W-1:0] mag_y_q, mag_y_d;
   logic [MAG_W-1:0] mag_max_q, mag_max_d;
   logic [MAG_W-1:0] period_q, period_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [SET_W-1:0] settle_q, settle_d;

   logic [PULSE_NUM_X_BITS-1:0] w_abs_x;
   logic [PULSE_NUM_Y_BITS-1:0] w_abs_y;
   logic [MAG_W-1:0]            w_abs_x_ext, w_abs_y_ext;
   logic                        w_accept;
   logic                        w_period_go;
   logic                        w_req_x, w_req_y;

   // Negating in full width maps the most negative count to 2^(N-1) unsigned.
   assign w_abs_x = cmd.pulse_num_x[PULSE_NUM_X_BITS-1] ?
                    ({PULSE_NUM_X_BITS{1'b0}} - cmd.pulse_num_x) : cmd.pulse_num_x;
   assign w_abs_y = cmd.pulse_num_y[PULSE_NUM_Y_BITS-1] ?
                    ({PULSE_NUM_Y_BITS{1'b0}} - cmd.pulse_num_y) : cmd.pulse_num_y;
   assign w_abs_x_ext = MAG_W'(w_abs_x);
   assign w_abs_y_ext = MAG_W'(w_abs_y);

   assign w_accept    = rdy_q & cmd.trigger;
   assign w_period_go = (state_q == ST_STEPPING) && (tmr_q == '0) && (period_q != mag_max_q);

`ifdef STEPPER_MOTION_CTRL_INTERP_EN
   localparam int ACC_W = MAG_W + 1;

   logic [ACC_W-1:0] acc_q, acc_d, w_acc_sum;
   logic [MAG_W-1:0] w_minor;
   logic             w_x_major, w_minor_hit;

   always_comb begin
      w_x_major   = (mag_x_q >= mag_y_q);
      w_minor     = w_x_major ? mag_y_q : mag_x_q;
      w_acc_sum   = acc_q + ACC_W'(w_minor);
      w_minor_hit = (w_acc_sum >= ACC_W'(mag_max_q));
      w_req_x     = w_period_go && (w_x_major || w_minor_hit);
      w_req_y     = w_period_go && (!w_x_major || w_minor_hit);
      acc_d       = acc_q;
      if (w_accept) begin
         acc_d = '0;
      end else if (w_period_go) begin
         acc_d = w_minor_hit ? (w_acc_sum - ACC_W'(mag_max_q)) : w_acc_sum;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end
`else
   always_comb begin
      w_req_x = w_period_go && (period_q < mag_x_q);
      w_req_y = w_period_go && (period_q < mag_y_q);
   end
`endif

   always_comb begin
      state_d   = state_q;
      rdy_d     = (state_q == ST_IDLE) && !w_accept;
      done_d    = 1'b0;
      dir_x_d   = dir_x_q;
      dir_y_d   = dir_y_q;
      servo_d   = servo_q;
      mag_x_d   = mag_x_q;
      mag_y_d   = mag_y_q;
      mag_max_d = mag_max_q;
      period_d  = period_q;
      tmr_d     = tmr_q;
      settle_d  = settle_q;
      case (state_q)
         ST_IDLE: begin
            if (w_accept) begin
               mag_x_d   = w_abs_x_ext;
               mag_y_d   = w_abs_y_ext;
               mag_max_d = (w_abs_x_ext >= w_abs_y_ext) ? w_abs_x_ext : w_abs_y_ext;
               dir_x_d   = cmd.pulse_num_x[PULSE_NUM_X_BITS-1];
               dir_y_d   = cmd.pulse_num_y[PULSE_NUM_Y_BITS-1];
               period_d  = '0;
               tmr_d     = '0;
               if (cmd.servo_pos != servo_q) begin
                  servo_d  = cmd.servo_pos;
                  settle_d = SET_INIT;
                  state_d  = ST_SERVO_WAIT;
               end else begin
                  state_d  = ST_STEPPING;
               end
            end
         end
         ST_SERVO_WAIT: begin
            if (settle_q == '0) begin
               state_d = ST_STEPPING;
            end else begin
               settle_d = settle_q - SET_W'(1);
            end
         end
         ST_STEPPING: begin
            // The counter reaches M on the wrap that ends the last period.
            if (period_q == mag_max_q) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else if (tmr_q == TMR_LAST) begin
               tmr_d    = '0;
               period_d = period_q + MAG_W'(1);
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         rdy_q     <= 1'b0;
         done_q    <= 1'b0;
         dir_x_q   <= 1'b0;
         dir_y_q   <= 1'b0;
         servo_q   <= SERVO_POS_UP;
         mag_x_q   <= '0;
         mag_y_q   <= '0;
         mag_max_q <= '0;
         period_q  <= '0;
         tmr_q     <= '0;
         settle_q  <= '0;
      end else begin
         state_q   <= state_d;
         rdy_q     <= rdy_d;
         done_q    <= done_d;
         dir_x_q   <= dir_x_d;
         dir_y_q   <= dir_y_d;
         servo_q   <= servo_d;
         mag_x_q   <= mag_x_d;
         mag_y_q   <= mag_y_d;
         mag_max_q <= mag_max_d;
         period_q  <= period_d;
         tmr_q     <= tmr_d;
         settle_q  <= settle_d;
      end
   end

   step_pulse_shaper #(
      .HIGH_CYCLES (STEP_HIGH_CYCLES)
   ) u_shaper_x (
      .clk        (clk),
      .reset      (reset),
      .step_req_i (w_req_x),
      .step_o     (step_x)
   );

   step_pulse_shaper #(
      .HIGH_CYCLES (STEP_HIGH_CYCLES)
   ) u_shaper_y (
      .clk        (clk),
      .reset      (reset),
      .step_req_i (w_req_y),
      .step_o     (step_y)
   );

   assign cmd.rdy       = rdy_q;
   assign cmd.done      = done_q;
   assign dir_x         = dir_x_q;
   assign dir_y         = dir_y_q;
   assign servo_pos_out = servo_q;

endmodule
`default_nettype wire
